// File: rtl/stego_embed_core.sv
// stego_embed_core: LSB message embedding between forward and inverse DCT.
// Coefficients at the configured block positions are quantised, get their
// quantised LSB replaced by a message bit popped from a small FIFO, and are
// dequantised with saturation. All other coefficients pass through with the
// same latency: a coefficient sampled at edge k leaves after edge k+3.
// Optional feature macro: STEGO_WHITEN_EN (XOR message bits with a 3-LFSR
// keystream before embedding; the LFSRs exist only when it is defined).
module stego_embed_core #(
  parameter int COEF_W     = 12,
  parameter int Q_STEP     = 18,
  parameter int Q_RECIP    = 228,
  parameter int EMBED_POS  = 43,
  parameter int EMBED_BITS = 1,
  parameter int MSG_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     embed_en,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_vld,
  input  logic                     msg_bit,
  input  logic                     msg_vld,
  output logic                     msg_rdy,
  output logic signed [COEF_W-1:0] coef_out,
  output logic                     out_vld,
  output logic                     out_emb,
  output logic                     blk_done,
  output logic [15:0]              miss_cnt
);

  localparam int AW = $clog2(MSG_DEPTH);
  // Product width for coef*Q_RECIP (reciprocal is at most 4096, 13 bits + sign).
  localparam int PW = COEF_W + 14;
  // Product width for q*Q_STEP (step is at most 255, 8 bits + sign + margin).
  localparam int RW = COEF_W + 10;
  localparam logic [6:0]              SLOT_LO = 7'(EMBED_POS);
  localparam logic [6:0]              SLOT_HI = 7'(EMBED_POS + EMBED_BITS - 1);
  localparam logic signed [PW-1:0]    RECIP_S = PW'(Q_RECIP);
  localparam logic signed [RW-1:0]    STEP_S  = RW'(Q_STEP);
  localparam logic signed [RW-1:0]    SAT_MAX = RW'((2 ** (COEF_W - 1)) - 1);
  localparam logic signed [RW-1:0]    SAT_MIN = -SAT_MAX - RW'(1);

  // Block index and message FIFO state
  logic [5:0]        idx_q, idx_d;
  logic              mem_q [MSG_DEPTH];
  logic              mem_d [MSG_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [15:0]       miss_q, miss_d;

  // Pipeline registers
  logic                     s1_vld_q, s1_vld_d, s1_emb_q, s1_emb_d;
  logic                     s1_bit_q, s1_bit_d, s1_last_q, s1_last_d;
  logic signed [COEF_W-1:0] s1_coef_q, s1_coef_d;
  logic                     s2_vld_q, s2_vld_d, s2_emb_q, s2_emb_d;
  logic                     s2_bit_q, s2_bit_d, s2_last_q, s2_last_d;
  logic signed [COEF_W-1:0] s2_coef_q, s2_coef_d;
  logic [COEF_W-2:0]        s2_qhi_q, s2_qhi_d;
  logic                     s3_vld_q, s3_vld_d, s3_emb_q, s3_emb_d;
  logic                     s3_last_q, s3_last_d;
  logic signed [RW-1:0]     s3_r_q, s3_r_d;
  logic signed [COEF_W-1:0] out_coef_q, out_coef_d;
  logic                     out_vld_q, out_vld_d, out_emb_q, out_emb_d;
  logic                     out_blk_q, out_blk_d;

  // Combinational helpers
  logic                     in_slot, fifo_empty, fifo_full;
  logic                     do_pop, do_push, do_miss, fifo_head, embed_bit;
  logic signed [PW-1:0]     prod;
  logic [PW-1:0]            prod_mag, q_mag;
  logic signed [COEF_W-1:0] q_emb;

  // Slot detection, FIFO handshake and pop/miss decision for the incoming coefficient
  always_comb begin
    in_slot    = embed_en && ({1'b0, idx_q} >= SLOT_LO) && ({1'b0, idx_q} <= SLOT_HI);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == (AW+1)'(MSG_DEPTH));
    do_push    = msg_vld && !fifo_full;
    do_pop     = coef_vld && in_slot && !fifo_empty;
    do_miss    = coef_vld && in_slot && fifo_empty;
    fifo_head  = mem_q[rd_ptr_q];
  end

`ifdef STEGO_WHITEN_EN
  logic [18:0] l1_q, l1_d;
  logic [21:0] l2_q, l2_d;
  logic [22:0] l3_q, l3_d;

  // Keystream generators step only when a message bit is actually consumed
  always_comb begin
    l1_d = l1_q;
    l2_d = l2_q;
    l3_d = l3_q;
    if (do_pop) begin
      l1_d = {l1_q[17:0], l1_q[18] ^ l1_q[17] ^ l1_q[16] ^ l1_q[13]};
      l2_d = {l2_q[20:0], l2_q[21] ^ l2_q[20]};
      l3_d = {l3_q[21:0], l3_q[22] ^ l3_q[21] ^ l3_q[20] ^ l3_q[7]};
    end
    embed_bit = fifo_head ^ l1_q[18] ^ l2_q[21] ^ l3_q[22];
  end

  // Keystream state, reseeded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_q <= 19'd1876;
      l2_q <= 22'd20007;
      l3_q <= 23'd14376;
    end else begin
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
    end
  end
`else
  // Without whitening the raw FIFO bit is embedded
  always_comb embed_bit = fifo_head;
`endif

  // Index counter, FIFO pointers/occupancy and saturating miss counter
  always_comb begin
    idx_d    = coef_vld ? idx_q + 6'd1 : idx_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    for (int i = 0; i < MSG_DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) mem_d[wr_ptr_q] = msg_bit;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    miss_d = (do_miss && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
  end

  // Stage 1: capture coefficient, embed decision and the bit to embed
  always_comb begin
    s1_vld_d  = coef_vld;
    s1_coef_d = s1_coef_q;
    s1_emb_d  = s1_emb_q;
    s1_bit_d  = s1_bit_q;
    s1_last_d = s1_last_q;
    if (coef_vld) begin
      s1_coef_d = coef_in;
      s1_emb_d  = do_pop;
      s1_bit_d  = embed_bit;
      s1_last_d = (idx_q == 6'd63);
    end
  end

  // Stage 2: quantise with round-half-away-from-zero; only bits above the LSB are kept
  always_comb begin
    prod      = PW'(s1_coef_q) * RECIP_S;
    prod_mag  = prod[PW-1] ? -prod : prod;
    q_mag     = (prod_mag >> 12) + PW'(prod_mag[11]);
    s2_vld_d  = s1_vld_q;
    s2_coef_d = s2_coef_q;
    s2_qhi_d  = s2_qhi_q;
    s2_emb_d  = s2_emb_q;
    s2_bit_d  = s2_bit_q;
    s2_last_d = s2_last_q;
    if (s1_vld_q) begin
      s2_coef_d = s1_coef_q;
      s2_qhi_d  = (COEF_W-1)'((prod[PW-1] ? -q_mag : q_mag) >> 1);
      s2_emb_d  = s1_emb_q;
      s2_bit_d  = s1_bit_q;
      s2_last_d = s1_last_q;
    end
  end

  // Stage 3: insert the bit as the quantised LSB and dequantise; others pass unchanged
  always_comb begin
    q_emb     = {s2_qhi_q, s2_bit_q};
    s3_vld_d  = s2_vld_q;
    s3_r_d    = s3_r_q;
    s3_emb_d  = s3_emb_q;
    s3_last_d = s3_last_q;
    if (s2_vld_q) begin
      s3_r_d    = s2_emb_q ? RW'(q_emb) * STEP_S : RW'(s2_coef_q);
      s3_emb_d  = s2_emb_q;
      s3_last_d = s2_last_q;
    end
  end

  // Output register: saturate to the coefficient range, flags only with valid
  always_comb begin
    out_coef_d = out_coef_q;
    if (s3_vld_q) begin
      if (s3_r_q > SAT_MAX)      out_coef_d = COEF_W'(SAT_MAX);
      else if (s3_r_q < SAT_MIN) out_coef_d = COEF_W'(SAT_MIN);
      else                       out_coef_d = COEF_W'(s3_r_q);
    end
    out_vld_d = s3_vld_q;
    out_emb_d = s3_vld_q && s3_emb_q;
    out_blk_d = s3_vld_q && s3_last_q;
  end

  // State registers; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_coef_q  <= '0;
      s1_emb_q   <= 1'b0;
      s1_bit_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_coef_q  <= '0;
      s2_qhi_q   <= '0;
      s2_emb_q   <= 1'b0;
      s2_bit_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_vld_q   <= 1'b0;
      s3_r_q     <= '0;
      s3_emb_q   <= 1'b0;
      s3_last_q  <= 1'b0;
      out_coef_q <= '0;
      out_vld_q  <= 1'b0;
      out_emb_q  <= 1'b0;
      out_blk_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      s1_vld_q   <= s1_vld_d;
      s1_coef_q  <= s1_coef_d;
      s1_emb_q   <= s1_emb_d;
      s1_bit_q   <= s1_bit_d;
      s1_last_q  <= s1_last_d;
      s2_vld_q   <= s2_vld_d;
      s2_coef_q  <= s2_coef_d;
      s2_qhi_q   <= s2_qhi_d;
      s2_emb_q   <= s2_emb_d;
      s2_bit_q   <= s2_bit_d;
      s2_last_q  <= s2_last_d;
      s3_vld_q   <= s3_vld_d;
      s3_r_q     <= s3_r_d;
      s3_emb_q   <= s3_emb_d;
      s3_last_q  <= s3_last_d;
      out_coef_q <= out_coef_d;
      out_vld_q  <= out_vld_d;
      out_emb_q  <= out_emb_d;
      out_blk_q  <= out_blk_d;
    end
  end

  assign msg_rdy  = !fifo_full;
  assign coef_out = out_coef_q;
  assign out_vld  = out_vld_q;
  assign out_emb  = out_emb_q;
  assign blk_done = out_blk_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_stego_embed_core.sv
// tb_stego_embed_core: scoreboard bench for stego_embed_core with default
// parameters. Expected outputs are computed when each coefficient is driven
// and compared when out_vld appears, including the cycle it must appear on.
module tb_stego_embed_core;

  localparam int EP = 43;
  localparam int EB = 1;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic embed_en = 1'b1;
  logic signed [11:0] coef_in = '0;
  logic coef_vld = 1'b0;
  logic msg_bit = 1'b0;
  logic msg_vld = 1'b0;
  logic msg_rdy;
  logic signed [11:0] coef_out;
  logic out_vld, out_emb, blk_done;
  logic [15:0] miss_cnt;

  stego_embed_core dut (
    .clk(clk), .rst(rst), .embed_en(embed_en),
    .coef_in(coef_in), .coef_vld(coef_vld),
    .msg_bit(msg_bit), .msg_vld(msg_vld), .msg_rdy(msg_rdy),
    .coef_out(coef_out), .out_vld(out_vld), .out_emb(out_emb),
    .blk_done(blk_done), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [11:0] coef;
    bit emb;
    bit last;
    int due;
  } exp_t;

  exp_t sb[$];
  bit   fifo_m[$];
  int   idx_m = 0;
  int   miss_m = 0;
  int   checks = 0;
  int   failures = 0;

`ifdef STEGO_WHITEN_EN
  logic [18:0] l1_m;
  logic [21:0] l2_m;
  logic [22:0] l3_m;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    fifo_m.delete();
    idx_m = 0;
    miss_m = 0;
`ifdef STEGO_WHITEN_EN
    l1_m = 19'd1876;
    l2_m = 22'd20007;
    l3_m = 23'd14376;
`endif
  endtask

  // Reference quantise / embed / dequantise / clamp in plain integer arithmetic
  function automatic int exp_embed(input int c, input bit b);
    int m, q, r;
    m = (c < 0 ? -c : c) * 228;
    q = (m + 2048) / 4096;
    if (c < 0) q = -q;
    q = b ? (q | 1) : (q & ~1);
    r = q * 18;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  task automatic send(input int c);
    exp_t e;
    bit b;
    @(posedge clk); #1;
    coef_vld = 1'b1;
    coef_in  = 12'(c);
    msg_vld  = 1'b0;
    e.coef = 12'(c);
    e.emb  = 1'b0;
    e.last = (idx_m == 63);
    e.due  = cyc + 4;
    if (embed_en && idx_m >= EP && idx_m <= EP + EB - 1) begin
      if (fifo_m.size() > 0) begin
        b = fifo_m.pop_front();
`ifdef STEGO_WHITEN_EN
        b = b ^ l1_m[18] ^ l2_m[21] ^ l3_m[22];
        l1_m = {l1_m[17:0], l1_m[18] ^ l1_m[17] ^ l1_m[16] ^ l1_m[13]};
        l2_m = {l2_m[20:0], l2_m[21] ^ l2_m[20]};
        l3_m = {l3_m[21:0], l3_m[22] ^ l3_m[21] ^ l3_m[20] ^ l3_m[7]};
`endif
        e.coef = 12'(exp_embed(c, b));
        e.emb  = 1'b1;
      end else if (miss_m < 65535) begin
        miss_m++;
      end
    end
    sb.push_back(e);
    idx_m = (idx_m + 1) % 64;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      coef_vld = 1'b0;
      msg_vld  = 1'b0;
    end
  endtask

  task automatic push(input bit b);
    @(posedge clk); #1;
    coef_vld = 1'b0;
    chk("msg_rdy_before_push", msg_rdy, (fifo_m.size() < DEPTH) ? 1 : 0);
    msg_vld = 1'b1;
    msg_bit = b;
    if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    coef_vld = 1'b0;
    msg_vld  = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    chk("miss_cnt", miss_cnt, miss_m);
  endtask

  // One 64-coefficient block; v43 goes to index 43, others are index value or random
  task automatic block(input int v43, input int gapmax, input bit rnd);
    int c;
    for (int i = 0; i < 64; i++) begin
      if (i == EP) c = v43;
      else c = rnd ? int'($urandom_range(4095, 0)) - 2048 : i;
      send(c);
      if (gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
    end
    drain();
    $display("block v43=%0d en=%0b gaps=%0d miss=%0d checks=%0d", v43, embed_en, gapmax, miss_cnt, checks);
  endtask

  // Output monitor: every valid output must match the oldest expectation, on time
  exp_t got;
  always @(negedge clk) begin
    if (out_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_vld", 1, 0);
      end else begin
        got = sb.pop_front();
        chk("coef_out", coef_out, got.coef);
        chk("out_emb", out_emb, got.emb);
        chk("blk_done", blk_done, got.last);
        chk("latency_cycle", cyc, got.due);
      end
    end else begin
      chk("flags_without_vld", {blk_done, out_emb}, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    chk("rst_coef_out", coef_out, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_emb", out_emb, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_msg_rdy", msg_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Positive, bit 1 and bit 0; negative; saturation both ends
    push(1'b1); block(100, 0, 1'b0);
    push(1'b0); block(100, 0, 1'b0);
    push(1'b1); block(-100, 0, 1'b0);
    push(1'b1); block(2047, 0, 1'b0);
    push(1'b0); block(-2048, 0, 1'b0);

    // Empty FIFO: two blocks of misses
    block(100, 0, 1'b0);
    block(100, 0, 1'b0);
    chk("miss_after_two_blocks", miss_cnt, 2);

    // Fill the FIFO; the ninth push is dropped
    push(1'b1); push(1'b0); push(1'b0); push(1'b1);
    push(1'b1); push(1'b0); push(1'b1); push(1'b0);
    push(1'b1);
    idle(1);
    chk("msg_rdy_full", msg_rdy, 0);

    // Pass-through mode leaves the FIFO untouched
    embed_en = 1'b0;
    block(100, 0, 1'b1);
    chk("msg_rdy_after_bypass", msg_rdy, 0);
    embed_en = 1'b1;

    // Consume the eight stored bits with gaps and random coefficients, then miss once
    for (int k = 0; k < 8; k++) block(int'($urandom_range(4095, 0)) - 2048, 2, 1'b1);
    chk("msg_rdy_after_consume", msg_rdy, 1);
    block(100, 0, 1'b0);

    // Reset in the middle of a block
    for (int i = 0; i < 20; i++) send(i);
    @(posedge clk); #3;
    coef_vld = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_coef_out", coef_out, 0);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_miss_cnt", miss_cnt, 0);
    chk("midrst_msg_rdy", msg_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    push(1'b1);
    block(-100, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
